// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_counter
// Purpose  : Centisecond stopwatch (00.00-99.99 s) with debounced start/stop,
//            lap and clear buttons feeding the seven-segment display driver.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_counter #(
    parameter int TICK_DIV        = 500000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int MAX_COUNT       = 9999
) (
    input  logic        clk50m_i,
    input  logic        rst_i,
    input  logic        btn_start_stop_n_i,
    input  logic        btn_lap_n_i,
    input  logic        btn_clear_n_i,
    output logic [15:0] count_o,
    output logic        running_o,
    output logic        lap_o,
    output logic        overflow_o
);

    localparam int c_PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int c_DEB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_DEB_W-1:0]   c_DEB_LAST   = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]          c_MAX        = 16'(MAX_COUNT);
    localparam int c_BTN_SS  = 0;
    localparam int c_BTN_LAP = 1;
    localparam int c_BTN_CLR = 2;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_LAP     = 2'd2
    } state_t;

    logic [2:0] w_btn_raw;
    logic [2:0] w_press;

    assign w_btn_raw = {btn_clear_n_i, btn_lap_n_i, btn_start_stop_n_i};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic [1:0]         r_sync;
        logic [c_DEB_W-1:0] r_stab_cnt;
        logic               r_level;
        logic               r_press;

        // The press pulse is registered on the same edge the debounced level
        // falls, so it is high for exactly the following cycle.
        always_ff @(posedge clk50m_i) begin
            if (rst_i) begin
                r_sync     <= 2'b11;
                r_stab_cnt <= '0;
                r_level    <= 1'b1;
                r_press    <= 1'b0;
            end else begin
                r_sync  <= {r_sync[0], w_btn_raw[gi]};
                r_press <= 1'b0;
                if (r_sync[1] == r_level) begin
                    r_stab_cnt <= '0;
                end else if (r_stab_cnt == c_DEB_LAST) begin
                    r_stab_cnt <= '0;
                    r_level    <= r_sync[1];
                    r_press    <= r_level;
                end else begin
                    r_stab_cnt <= r_stab_cnt + 1'b1;
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    state_t                 r_state, w_state_next;
    logic [15:0]            r_live, w_live_next;
    logic [15:0]            r_disp, w_disp_next;
    logic [c_PRESC_W-1:0]   r_presc, w_presc_next;
    logic                   r_ovf, w_ovf_next;
    logic                   w_active;
    logic                   w_tick;
    logic                   w_sat;

    assign w_active = (r_state != ST_STOPPED);
    assign w_tick   = w_active && (r_presc == c_PRESC_LAST);
    assign w_sat    = w_tick && (r_live >= c_MAX);

    always_ff @(posedge clk50m_i) begin
        if (rst_i) begin
            r_state <= ST_STOPPED;
            r_live  <= '0;
            r_disp  <= '0;
            r_presc <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_live  <= w_live_next;
            r_disp  <= w_disp_next;
            r_presc <= w_presc_next;
            r_ovf   <= w_ovf_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_live_next  = r_live;
        w_presc_next = r_presc;
        w_ovf_next   = r_ovf;

        if (w_press[c_BTN_CLR]) begin
            w_state_next = ST_STOPPED;
            w_live_next  = '0;
            w_presc_next = '0;
            w_ovf_next   = 1'b0;
        end else begin
            if (w_active) begin
                w_presc_next = w_tick ? '0 : r_presc + 1'b1;
            end
            if (w_tick && !w_sat) begin
                w_live_next = r_live + 16'd1;
            end
            // Saturation forces STOPPED regardless of a coincident press.
            if (w_sat) begin
                w_ovf_next   = 1'b1;
                w_state_next = ST_STOPPED;
            end else if (w_press[c_BTN_SS]) begin
                if (r_state == ST_STOPPED) begin
                    w_state_next = r_ovf ? ST_STOPPED : ST_RUNNING;
                end else begin
                    w_state_next = ST_STOPPED;
                end
            end else if (w_press[c_BTN_LAP]) begin
                if (r_state == ST_RUNNING) begin
                    w_state_next = ST_LAP;
                end else if (r_state == ST_LAP) begin
                    w_state_next = ST_RUNNING;
                end
            end
        end

        w_disp_next = (w_state_next == ST_LAP) ? r_disp : w_live_next;
    end

    assign count_o    = r_disp;
    assign running_o  = (r_state != ST_STOPPED);
    assign lap_o      = (r_state == ST_LAP);
    assign overflow_o = r_ovf;

endmodule
`default_nettype wire

// File: doc/stopwatch_counter.md
# stopwatch_counter

Centisecond stopwatch that produces the 16-bit binary value (0..9999, i.e. 00.00-99.99 s) driven into the four-digit seven-segment driver's `hex_data_bus_i`. It debounces three raw active-low board buttons (start/stop, lap, clear) and runs a 10 ms tick prescaler. A small state machine controls counting and lap-freeze of the displayed value. It sits directly upstream of the display driver in the top level.

## Interface
- `TICK_DIV`, 500000: clk cycles per count increment (10 ms at 50 MHz); ≥2.
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable synchronized samples required to accept a button level change (20 ms); ≥2.
- `MAX_COUNT`, 9999: terminal count; must fit 16 bits.
- `clk50m_i` input 1: 50 MHz system clock, all logic on rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `btn_start_stop_n_i` input 1: raw, asynchronous, active-low start/stop button.
- `btn_lap_n_i` input 1: raw, asynchronous, active-low lap button.
- `btn_clear_n_i` input 1: raw, asynchronous, active-low clear button.
- `count_o` output 16: displayed value, binary 0..MAX_COUNT; feeds the display driver.
- `running_o` output 1: high in RUNNING or LAP.
- `lap_o` output 1: high in LAP (display frozen).
- `overflow_o` output 1: sticky; set when the count saturates at MAX_COUNT.

## Operation
- Per button, the conditioning chain is:
  - 2-flop synchronizer.
  - Stability counter: a debounced level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it. Any agreeing sample restarts the counter.
  - Press pulse: exactly one cycle, on the debounced 1→0 transition. Release produces nothing. Holding the button gives one press only.
- Debounced levels reset to 1 (released), so no spurious press after reset.
- Internal `live` count register: 16 bit. `count_o` is driven from a separate `disp` register.
- Prescaler, 0..TICK_DIV-1:
  - Advances only in RUNNING/LAP and holds its value in STOPPED, so pause/resume keeps the fraction.
  - A tick is the cycle in which the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
- On a tick, if `live` < MAX_COUNT then `live` increments.
- Tick with `live` == MAX_COUNT:
  - `live` holds at MAX_COUNT.
  - `overflow_o` is set.
  - State goes to STOPPED.
- FSM states: STOPPED (reset), RUNNING, LAP.
  - STOPPED + start_stop → RUNNING. Ignored if `overflow_o` = 1; only clear recovers.
  - STOPPED + lap → ignored.
  - RUNNING + start_stop → STOPPED.
  - RUNNING + lap → LAP; `disp` holds the value it had in that cycle.
  - LAP + lap → RUNNING; `disp` resumes following `live`.
  - LAP + start_stop → STOPPED; `disp` resumes following `live`.
  - Clear in any state → STOPPED. It also zeroes `live`, `disp`, the prescaler and `overflow_o`.
- Press priority in the same cycle: clear > start_stop > lap. Lower-priority presses in that cycle are dropped.
- A press in the same cycle as a tick:
  - The tick's increment is applied.
  - Then the state transition occurs.
  - Exception: clear wins and the result is 0.
- `disp` loads `live`'s next value every cycle, except in LAP.

## Timing
- Reset (`rst_i` high at an edge), effective on that edge, including mid-count or mid-debounce:
  - State STOPPED.
  - `count_o` = 0, `running_o` = 0, `lap_o` = 0, `overflow_o` = 0.
  - Prescaler = 0, stability counters = 0, debounced levels = 1.
- Button latency: a held press yields its one-cycle press pulse 2 (synchronizer) + DEBOUNCE_CYCLES + 1 cycles after the pin first falls, if the level is stable throughout.
- From a press pulse to outputs: state, `running_o`, `lap_o` and `count_o` all update on the edge ending the press-pulse cycle. This is one-cycle registered latency.
- Counting:
  - The first tick after entering RUNNING from reset/clear occurs TICK_DIV cycles after entry.
  - `count_o` shows the increment on the edge ending the tick cycle, and is thereafter stable for TICK_DIV cycles.
- `count_o` never exceeds MAX_COUNT and never wraps.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Bench uses TICK_DIV=4, DEBOUNCE_CYCLES=3, MAX_COUNT=12.
- **Reset and start:** assert `rst_i` mid-run, then press start_stop → all outputs 0 during reset. After the press, `running_o` = 1 and `count_o` steps 1, 2, 3 every 4 cycles.
- **Bounce rejection:** toggle `btn_start_stop_n_i` 0/1 every 2 cycles for 20 cycles, then hold 0 → exactly one press. State changes once, 6 cycles after the final fall.
- **Lap:**
  - Press lap at `count_o` = 5 → `lap_o` = 1 and `count_o` frozen at 5 while `live` keeps counting.
  - After 12 cycles, press lap again → `count_o` jumps to the live value (8).
- **Pause/resume:**
  - Press start_stop 2 cycles after the tick that set count 3 → the count holds at 3.
  - Resume → next tick occurs 2 cycles after entering RUNNING.
- **Overflow:**
  - Run to 12 → `count_o` = 12, `overflow_o` = 1, `running_o` = 0.
  - A start_stop press is then ignored.
  - Clear → all zero.
- **Simultaneous presses:** clear and start_stop released to the same debounced edge while RUNNING at count 7 → STOPPED, `count_o` = 0, `running_o` = 0.
